qpi_channel_arbiter: RTL and testbench

- Shares the two QPI transmit channels between the frame reader and the frame writer.
- C0 carries read requests (RdLine), C1 carries write requests (WrLine/WrFence).
- Each channel has its own arbiter: combinational same-cycle grant back to the requester, then a registered output stage that drives the QPI TX channel.
- Bounded-burst round-robin policy; back-pressure from the almost-full signals.

---
 rtl/qpi_channel_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_qpi_channel_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpi_channel_arbiter.sv
// qpi_channel_arbiter
//   Shares the QPI TX channels between the frame reader and the frame writer.
//   C0 carries read requests, C1 carries write requests (header + cache line).
//   Each channel uses a bounded-burst round-robin arbiter.
//   Grants go back to the requesters combinationally in the same cycle.
//   A registered stage then drives the TX channel one cycle later.
//
// Ports
//   clk, resetb             clock; synchronous active-low reset
//   i_afu_en                AFU enable; low behaves exactly like reset
//   i_c0/c1_almostfull      TX back-pressure; blocks all grants on that channel
//   i_{rd,wr}_c0_req/hdr    C0 requests from reader / writer
//   i_{rd,wr}_c1_req/hdr    C1 requests from reader / writer
//   i_{rd,wr}_c1_data       C1 cache-line data
//   o_{rd,wr}_c{0,1}_grant  same-cycle accepts, combinational
//   o_tx0_valid/hdr         registered C0 TX request
//   o_tx1_valid/hdr/data    registered C1 TX request
//
// Optional feature, macro QPI_ARB_STATS_EN
//   Adds 32-bit wrapping grant counters o_{rd,wr}_c{0,1}_cnt.
//   Adds o_af_stall_cnt, which counts cycles where a request was blocked only
//   by almost-full.
//   Arbitration behaviour is the same with or without the macro.
module qpi_channel_arbiter #(
  parameter int unsigned HDR_WIDTH   = 61,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned BURST_CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  i_afu_en,
  input  logic                  i_c0_almostfull,
  input  logic                  i_c1_almostfull,
  input  logic                  i_rd_c0_req,
  input  logic                  i_wr_c0_req,
  input  logic [HDR_WIDTH-1:0]  i_rd_c0_hdr,
  input  logic [HDR_WIDTH-1:0]  i_wr_c0_hdr,
  input  logic                  i_rd_c1_req,
  input  logic                  i_wr_c1_req,
  input  logic [HDR_WIDTH-1:0]  i_rd_c1_hdr,
  input  logic [HDR_WIDTH-1:0]  i_wr_c1_hdr,
  input  logic [DATA_WIDTH-1:0] i_rd_c1_data,
  input  logic [DATA_WIDTH-1:0] i_wr_c1_data,
  output logic                  o_rd_c0_grant,
  output logic                  o_wr_c0_grant,
  output logic                  o_rd_c1_grant,
  output logic                  o_wr_c1_grant,
  output logic                  o_tx0_valid,
  output logic [HDR_WIDTH-1:0]  o_tx0_hdr,
  output logic                  o_tx1_valid,
  output logic [HDR_WIDTH-1:0]  o_tx1_hdr,
  output logic [DATA_WIDTH-1:0] o_tx1_data
`ifdef QPI_ARB_STATS_EN
  ,
  output logic [31:0]           o_rd_c0_cnt,
  output logic [31:0]           o_wr_c0_cnt,
  output logic [31:0]           o_rd_c1_cnt,
  output logic [31:0]           o_wr_c1_cnt,
  output logic [31:0]           o_af_stall_cnt
`endif
);

  localparam logic [BURST_CNT_W-1:0] BurstMax = BURST_CNT_W'(BURST_LEN);

  logic                         w_run;
  logic [1:0]                   w_rd_req;
  logic [1:0]                   w_wr_req;
  logic [1:0]                   w_af;
  logic [1:0]                   w_rd_gnt;
  logic [1:0]                   w_wr_gnt;
  // Owner per channel: 0 = reader, 1 = writer.
  logic [1:0]                   r_owner;
  logic [1:0]                   w_owner_nxt;
  logic [1:0][BURST_CNT_W-1:0]  r_burst_cnt;
  logic [1:0][BURST_CNT_W-1:0]  w_burst_cnt_nxt;

  assign w_run    = resetb & i_afu_en;
  assign w_rd_req = {i_rd_c1_req, i_rd_c0_req};
  assign w_wr_req = {i_wr_c1_req, i_wr_c0_req};
  assign w_af     = {i_c1_almostfull, i_c0_almostfull};

  // Index 0 is C0 and index 1 is C1. Both channels use the same logic.
  always_comb begin
    w_rd_gnt        = '0;
    w_wr_gnt        = '0;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    for (int ch = 0; ch < 2; ch++) begin
      if (w_run && !w_af[ch]) begin
        if (w_rd_req[ch] && w_wr_req[ch]) begin
          // While the burst budget lasts, the owner keeps the channel.
          // After that, the other requester gets it.
          w_wr_gnt[ch] = (r_burst_cnt[ch] < BurstMax) ? r_owner[ch] : !r_owner[ch];
          w_rd_gnt[ch] = !w_wr_gnt[ch];
        end else begin
          w_rd_gnt[ch] = w_rd_req[ch];
          w_wr_gnt[ch] = w_wr_req[ch];
        end
      end
      if (w_rd_gnt[ch] || w_wr_gnt[ch]) begin
        if (w_wr_gnt[ch] == r_owner[ch]) begin
          if (r_burst_cnt[ch] < BurstMax) begin
            w_burst_cnt_nxt[ch] = r_burst_cnt[ch] + 1'b1;
          end
        end else begin
          w_owner_nxt[ch]     = w_wr_gnt[ch];
          w_burst_cnt_nxt[ch] = BURST_CNT_W'(1);
        end
      end
    end
  end

  assign o_rd_c0_grant = w_rd_gnt[0];
  assign o_wr_c0_grant = w_wr_gnt[0];
  assign o_rd_c1_grant = w_rd_gnt[1];
  assign o_wr_c1_grant = w_wr_gnt[1];

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Registered TX stage. Header and data hold their value when nothing is granted.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      o_tx0_valid <= 1'b0;
      o_tx0_hdr   <= '0;
      o_tx1_valid <= 1'b0;
      o_tx1_hdr   <= '0;
      o_tx1_data  <= '0;
    end else begin
      o_tx0_valid <= w_rd_gnt[0] | w_wr_gnt[0];
      o_tx1_valid <= w_rd_gnt[1] | w_wr_gnt[1];
      if (w_rd_gnt[0]) begin
        o_tx0_hdr <= i_rd_c0_hdr;
      end else if (w_wr_gnt[0]) begin
        o_tx0_hdr <= i_wr_c0_hdr;
      end
      if (w_rd_gnt[1]) begin
        o_tx1_hdr  <= i_rd_c1_hdr;
        o_tx1_data <= i_rd_c1_data;
      end else if (w_wr_gnt[1]) begin
        o_tx1_hdr  <= i_wr_c1_hdr;
        o_tx1_data <= i_wr_c1_data;
      end
    end
  end

`ifdef QPI_ARB_STATS_EN
  logic w_af_stall;

  // Almost-full is the only blocker here: reset and disable are already
  // excluded by w_run.
  assign w_af_stall = w_run && ((w_af[0] && (w_rd_req[0] || w_wr_req[0])) ||
                                (w_af[1] && (w_rd_req[1] || w_wr_req[1])));

  always_ff @(posedge clk) begin
    if (!w_run) begin
      o_rd_c0_cnt    <= '0;
      o_wr_c0_cnt    <= '0;
      o_rd_c1_cnt    <= '0;
      o_wr_c1_cnt    <= '0;
      o_af_stall_cnt <= '0;
    end else begin
      o_rd_c0_cnt    <= o_rd_c0_cnt + 32'(w_rd_gnt[0]);
      o_wr_c0_cnt    <= o_wr_c0_cnt + 32'(w_wr_gnt[0]);
      o_rd_c1_cnt    <= o_rd_c1_cnt + 32'(w_rd_gnt[1]);
      o_wr_c1_cnt    <= o_wr_c1_cnt + 32'(w_wr_gnt[1]);
      o_af_stall_cnt <= o_af_stall_cnt + 32'(w_af_stall);
    end
  end
`endif

endmodule

// File: tb/tb_qpi_channel_arbiter.sv
// Testbench for qpi_channel_arbiter.
//   A table of per-cycle vectors gives the inputs and hand-computed grants.
//   Expected TX outputs are modelled from those expected grants.
//   Hand-written sequences cover long back-pressure and a disable in mid-burst.
//   When QPI_ARB_STATS_EN is defined, the statistics counters are also checked.
module tb_qpi_channel_arbiter;

  localparam int HW = 61;
  localparam int DW = 512;

  logic          clk;
  logic          resetb;
  logic          afu_en;
  logic          c0_af, c1_af;
  logic          rd_c0_req, wr_c0_req, rd_c1_req, wr_c1_req;
  logic [HW-1:0] rd_c0_hdr, wr_c0_hdr, rd_c1_hdr, wr_c1_hdr;
  logic [DW-1:0] rd_c1_data, wr_c1_data;
  logic          rd_c0_grant, wr_c0_grant, rd_c1_grant, wr_c1_grant;
  logic          tx0_valid, tx1_valid;
  logic [HW-1:0] tx0_hdr, tx1_hdr;
  logic [DW-1:0] tx1_data;
`ifdef QPI_ARB_STATS_EN
  logic [31:0]   rd_c0_cnt, wr_c0_cnt, rd_c1_cnt, wr_c1_cnt, af_stall_cnt;
`endif

  qpi_channel_arbiter #(
    .HDR_WIDTH  (HW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (4),
    .BURST_CNT_W(3)
  ) dut (
    .clk            (clk),
    .resetb         (resetb),
    .i_afu_en       (afu_en),
    .i_c0_almostfull(c0_af),
    .i_c1_almostfull(c1_af),
    .i_rd_c0_req    (rd_c0_req),
    .i_wr_c0_req    (wr_c0_req),
    .i_rd_c0_hdr    (rd_c0_hdr),
    .i_wr_c0_hdr    (wr_c0_hdr),
    .i_rd_c1_req    (rd_c1_req),
    .i_wr_c1_req    (wr_c1_req),
    .i_rd_c1_hdr    (rd_c1_hdr),
    .i_wr_c1_hdr    (wr_c1_hdr),
    .i_rd_c1_data   (rd_c1_data),
    .i_wr_c1_data   (wr_c1_data),
    .o_rd_c0_grant  (rd_c0_grant),
    .o_wr_c0_grant  (wr_c0_grant),
    .o_rd_c1_grant  (rd_c1_grant),
    .o_wr_c1_grant  (wr_c1_grant),
    .o_tx0_valid    (tx0_valid),
    .o_tx0_hdr      (tx0_hdr),
    .o_tx1_valid    (tx1_valid),
    .o_tx1_hdr      (tx1_hdr),
    .o_tx1_data     (tx1_data)
`ifdef QPI_ARB_STATS_EN
    ,
    .o_rd_c0_cnt    (rd_c0_cnt),
    .o_wr_c0_cnt    (wr_c0_cnt),
    .o_rd_c1_cnt    (rd_c1_cnt),
    .o_wr_c1_cnt    (wr_c1_cnt),
    .o_af_stall_cnt (af_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected grants g = {rd_c0, wr_c0, rd_c1, wr_c1}.
  typedef struct {
    logic       rstb, en;
    logic       r0, w0, a0;
    logic       r1, w1, a1;
    logic [3:0] g;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model of the registered TX stage, driven by the expected grants.
  logic          e_tx0v, e_tx1v;
  logic [HW-1:0] e_tx0h, e_tx1h;
  logic [DW-1:0] e_tx1d;

  function automatic vec_t mk(input logic rstb, en, r0, w0, a0, r1, w1, a1,
                              input logic [3:0] g);
    vec_t v;
    v.rstb = rstb; v.en = en;
    v.r0 = r0; v.w0 = w0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.g = g;
    return v;
  endfunction

  // Every header and data word is tagged with the cycle number.
  // This lets a stale or swapped payload be detected.
  function automatic logic [HW-1:0] hdr_of(input int base, input int c);
    return HW'(base + c);
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [31:0] base, input int c);
    return {(DW/32){base + 32'(c)}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    resetb     = v.rstb;
    afu_en     = v.en;
    rd_c0_req  = v.r0;
    wr_c0_req  = v.w0;
    c0_af      = v.a0;
    rd_c1_req  = v.r1;
    wr_c1_req  = v.w1;
    c1_af      = v.a1;
    rd_c0_hdr  = hdr_of(32'h1000, cyc);
    wr_c0_hdr  = hdr_of(32'h2000, cyc);
    rd_c1_hdr  = hdr_of(32'h3000, cyc);
    wr_c1_hdr  = hdr_of(32'h4000, cyc);
    rd_c1_data = data_of(32'hA5A50000, cyc);
    wr_c1_data = data_of(32'h5A5A0000, cyc);
    #1;
    chk("rd_c0_grant", DW'(rd_c0_grant), DW'(v.g[3]));
    chk("wr_c0_grant", DW'(wr_c0_grant), DW'(v.g[2]));
    chk("rd_c1_grant", DW'(rd_c1_grant), DW'(v.g[1]));
    chk("wr_c1_grant", DW'(wr_c1_grant), DW'(v.g[0]));
    if (!(v.rstb && v.en)) begin
      e_tx0v = 1'b0; e_tx0h = '0;
      e_tx1v = 1'b0; e_tx1h = '0; e_tx1d = '0;
    end else begin
      e_tx0v = v.g[3] | v.g[2];
      e_tx1v = v.g[1] | v.g[0];
      if (v.g[3]) e_tx0h = rd_c0_hdr;
      else if (v.g[2]) e_tx0h = wr_c0_hdr;
      if (v.g[1]) begin
        e_tx1h = rd_c1_hdr; e_tx1d = rd_c1_data;
      end else if (v.g[0]) begin
        e_tx1h = wr_c1_hdr; e_tx1d = wr_c1_data;
      end
    end
    @(posedge clk);
    #1;
    chk("tx0_valid", DW'(tx0_valid), DW'(e_tx0v));
    chk("tx0_hdr",   DW'(tx0_hdr),   DW'(e_tx0h));
    chk("tx1_valid", DW'(tx1_valid), DW'(e_tx1v));
    chk("tx1_hdr",   DW'(tx1_hdr),   DW'(e_tx1h));
    chk("tx1_data",  tx1_data,       e_tx1d);
    cyc++;
  endtask

  vec_t tbl[25];

  initial begin
    resetb = 1'b0; afu_en = 1'b0; c0_af = 1'b0; c1_af = 1'b0;
    rd_c0_req = 1'b0; wr_c0_req = 1'b0; rd_c1_req = 1'b0; wr_c1_req = 1'b0;
    rd_c0_hdr = '0; wr_c0_hdr = '0; rd_c1_hdr = '0; wr_c1_hdr = '0;
    rd_c1_data = '0; wr_c1_data = '0;
    e_tx0v = 1'b0; e_tx1v = 1'b0; e_tx0h = '0; e_tx1h = '0; e_tx1d = '0;
    repeat (2) @(posedge clk);

    // Field order: rstb, en, r0, w0, a0, r1, w1, a1, g.
    // Requests that are pending during reset get no grant.
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 4'b0000);
    // Single reader on C0. C0 state becomes reader, count 1.
    tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 4'b1000);
    // C1 contention from reset state: reader x4, writer x4, then reader.
    for (int i = 2; i <= 5; i++) tbl[i] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0010);
    for (int i = 6; i <= 9; i++) tbl[i] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0001);
    tbl[10] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0010);
    // C0 back-pressure with both requesting. State stays reader, count 1.
    for (int i = 11; i <= 13; i++) tbl[i] = mk(1, 1, 1, 1, 1, 0, 0, 0, 4'b0000);
    // Released: the reader finishes its burst (count 2, 3, 4), then the writer.
    for (int i = 14; i <= 16; i++) tbl[i] = mk(1, 1, 1, 1, 0, 0, 0, 0, 4'b1000);
    tbl[17] = mk(1, 1, 1, 1, 0, 0, 0, 0, 4'b0100);
    // Almost-full rising in the same cycle as the requests: no grant.
    tbl[18] = mk(1, 1, 1, 1, 1, 0, 0, 0, 4'b0000);
    // A lone reader takes ownership back. Then it wins as owner with count 1 < 4.
    tbl[19] = mk(1, 1, 1, 0, 0, 0, 0, 0, 4'b1000);
    tbl[20] = mk(1, 1, 1, 1, 0, 0, 0, 0, 4'b1000);
    // afu_en low acts as reset. Re-enabled, both channels start from the reader.
    tbl[21] = mk(1, 0, 1, 1, 0, 1, 1, 0, 4'b0000);
    tbl[22] = mk(1, 1, 1, 1, 0, 1, 1, 0, 4'b1010);
    // C1 almost-full blocks a lone writer. Then the C1 reader resumes as owner.
    tbl[23] = mk(1, 1, 0, 0, 0, 0, 1, 1, 4'b0000);
    tbl[24] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0010);

    for (int i = 0; i < 25; i++) step(tbl[i]);

    // Ten cycles of C0 back-pressure. C0 state is reader with count 1.
    for (int i = 0; i < 10; i++) step(mk(1, 1, 1, 1, 1, 0, 0, 0, 4'b0000));
    // The saved state is used on release: reader x3 to reach 4, then writer.
    for (int i = 0; i < 3; i++) step(mk(1, 1, 1, 1, 0, 0, 0, 0, 4'b1000));
    step(mk(1, 1, 1, 1, 0, 0, 0, 0, 4'b0100));

    // C1 is reader with count 2. Reader x2, then writer x3, leaving writer with count 3.
    for (int i = 0; i < 2; i++) step(mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0010));
    for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0001));
    // Disable in mid-burst. Then re-enable with only the writer requesting.
    step(mk(1, 0, 0, 0, 0, 1, 1, 0, 4'b0000));
    step(mk(1, 1, 0, 0, 0, 0, 1, 0, 4'b0001));
    // If the writer restarted at count 1, it keeps 3 more grants before the reader.
    for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0001));
    step(mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0010));

`ifdef QPI_ARB_STATS_EN
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < 7; i++) step(mk(1, 1, 1, 0, 0, 0, 0, 0, 4'b1000));
    for (int i = 0; i < 5; i++) step(mk(1, 1, 0, 1, 0, 0, 0, 0, 4'b0100));
    for (int i = 0; i < 3; i++) step(mk(1, 1, 1, 0, 1, 0, 0, 0, 4'b0000));
    chk("rd_c0_cnt",    DW'(rd_c0_cnt),    DW'(32'd7));
    chk("wr_c0_cnt",    DW'(wr_c0_cnt),    DW'(32'd5));
    chk("rd_c1_cnt",    DW'(rd_c1_cnt),    DW'(32'd0));
    chk("wr_c1_cnt",    DW'(wr_c1_cnt),    DW'(32'd0));
    chk("af_stall_cnt", DW'(af_stall_cnt), DW'(32'd3));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
